// File: rtl/instruction_mem_banked.sv
// Banked instruction memory: NUM_BANKS programs of DEPTH words, fetched from the active bank and loaded by a stream.
// Fetch latency 1 cycle, no bubbles; fetch stalls only while the active bank is being rewritten; load_ready is held for a whole load.
module instruction_mem_banked #(
  parameter int INSTR_W = 9,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W = 2,
  parameter logic [INSTR_W-1:0] HALT_WORD = 9'b0111_00_010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               addr_err,
  input  logic [BANK_W-1:0]  bank_sel,
  input  logic               bank_sel_we,
  output logic [BANK_W-1:0]  active_bank,
  input  logic               load_start,
  input  logic [BANK_W-1:0]  load_bank,
  input  logic               load_valid,
  input  logic               load_last,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               load_done,
  output logic [ADDR_W:0]    load_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W:0]   BANKS_V  = (BANK_W+1)'(NUM_BANKS);

  typedef enum logic {IDLE, LOADING} load_state_t;

  load_state_t state;
  load_state_t state_nxt;

  logic [INSTR_W-1:0] mem [NUM_BANKS][DEPTH];

  logic [BANK_W-1:0] load_bank_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic              start_ok;
  logic              sel_ok;
  logic              wr_en;
  logic              load_end;
  logic              fetch_acc;
  logic              fetch_in_range;

  assign start_ok       = load_start && ({1'b0, load_bank} < BANKS_V);
  assign sel_ok         = bank_sel_we && ({1'b0, bank_sel} < BANKS_V);
  assign wr_en          = load_valid && load_ready;
  assign load_end       = wr_en && (load_last || (wr_ptr == LAST_PTR));
  assign fetch_ready    = !((state == LOADING) && (load_bank_q == active_bank));
  assign fetch_acc      = fetch_req && fetch_ready;
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = LOADING;
      LOADING: if (load_end) state_nxt = IDLE;
    endcase
  end

  // load_ready is a decode of the state flop, so it is glitch-free and stays high for every LOADING cycle.
  always_comb begin
    load_ready = (state == LOADING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_bank_q <= '0;
      wr_ptr      <= '0;
      load_done   <= 1'b0;
      load_count  <= '0;
    end else begin
      load_done <= load_end;
      if ((state == IDLE) && start_ok) begin
        load_bank_q <= load_bank;
        wr_ptr      <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (load_end) begin
        load_count <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
      end
    end
  end

  // Reset wins over a write offered on the same edge; contents are otherwise never cleared.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[load_bank_q][wr_ptr[IDX_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_bank <= '0;
    end else if (sel_ok) begin
      active_bank <= bank_sel;
    end
  end

  // The fetch reads active_bank before a same-cycle bank select takes effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      instr_valid <= fetch_acc;
      addr_err    <= fetch_acc && !fetch_in_range;
      if (fetch_acc) begin
        instr <= fetch_in_range ? mem[active_bank][fetch_addr[IDX_W-1:0]] : HALT_WORD;
      end
    end
  end

endmodule

// File: tb/tb_instruction_mem_banked.sv
// Randomized bench for two builds (256x4 and 16x3) against array models of what each bank should hold.
module tb_instruction_mem_banked;

  localparam logic [8:0] HALT = 9'b0111_00_010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       reset, fetch_req, fetch_ready, instr_valid, addr_err, bank_sel_we;
  logic       load_start, load_valid, load_last, load_ready, load_done;
  logic [7:0] fetch_addr;
  logic [8:0] instr, load_data, load_count;
  logic [1:0] bank_sel, active_bank, load_bank;

  logic       s_reset, s_fetch_req, s_fetch_ready, s_instr_valid, s_addr_err, s_bank_sel_we;
  logic       s_load_start, s_load_valid, s_load_last, s_load_ready, s_load_done;
  logic [7:0] s_fetch_addr;
  logic [8:0] s_instr, s_load_data, s_load_count;
  logic [1:0] s_bank_sel, s_active_bank, s_load_bank;

  logic [8:0] mref [4][256];
  logic [8:0] sref [16];
  logic [8:0] wdat [256];
  logic [8:0] ndat [16];

  instruction_mem_banked dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err),
    .bank_sel(bank_sel), .bank_sel_we(bank_sel_we), .active_bank(active_bank),
    .load_start(load_start), .load_bank(load_bank), .load_valid(load_valid),
    .load_last(load_last), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .load_count(load_count)
  );

  instruction_mem_banked #(.DEPTH(16), .NUM_BANKS(3), .BANK_W(2)) dut16 (
    .clk(clk), .reset(s_reset),
    .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr), .fetch_ready(s_fetch_ready),
    .instr(s_instr), .instr_valid(s_instr_valid), .addr_err(s_addr_err),
    .bank_sel(s_bank_sel), .bank_sel_we(s_bank_sel_we), .active_bank(s_active_bank),
    .load_start(s_load_start), .load_bank(s_load_bank), .load_valid(s_load_valid),
    .load_last(s_load_last), .load_data(s_load_data), .load_ready(s_load_ready),
    .load_done(s_load_done), .load_count(s_load_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams wdat[0..n-1] into bank b and reports what the load port did.
  task automatic run_load(input int b, input int n, input bit use_last, input bit gaps,
                          output int pulses, output int rdy_lat, output int fr_hi,
                          output logic [8:0] cnt);
    int sent;
    sent = 0; pulses = 0; rdy_lat = -1; fr_hi = 0; cnt = '0;
    load_start = 1'b1; load_bank = 2'(b);
    tick();
    load_start = 1'b0;
    for (int c = 1; c <= 4 * n + 20; c++) begin
      if (load_ready && rdy_lat < 0) rdy_lat = c;
      if (load_ready && fetch_ready) fr_hi++;
      load_valid = !gaps || ($urandom_range(0, 3) != 0);
      load_data  = wdat[sent];
      load_last  = use_last && (sent == n - 1);
      if (load_valid && load_ready) sent++;
      tick();
      if (load_done) begin pulses++; cnt = load_count; end
      if (sent >= n) break;
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_tests++; if (instr !== 9'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 000", instr); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_tests++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    n_tests++; if (active_bank !== 2'd0) begin n_fail++; $display("FAIL reset_active_bank: got %0d want 0", active_bank); end
    n_tests++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
    n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    n_tests++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL reset_load_count: got %0d want 0", load_count); end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready); end
    fetch_req = 1'b1; fetch_addr = 8'd200;
    tick();
    fetch_req = 1'b0;
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_fetch_valid: got %b want 1", instr_valid); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if ({instr_valid, instr} !== 10'h0) begin n_fail++; $display("FAIL reset_after_fetch: got valid=%b instr=%h want 0/000", instr_valid, instr); end
  endtask

  task automatic test_load_fetch();
    int pulses, lat, frh;
    logic [8:0] cnt;
    for (int i = 0; i < 20; i++) wdat[i] = 9'h100 + 9'(i);
    run_load(0, 20, 1'b1, 1'b0, pulses, lat, frh, cnt);
    for (int i = 0; i < 20; i++) mref[0][i] = wdat[i];
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL load_ready_latency: got %0d want 1", lat); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL load_done_pulses: got %0d want 1", pulses); end
    n_tests++; if (cnt !== 9'd20) begin n_fail++; $display("FAIL load_count_20: got %0d want 20", cnt); end
    tick();
    n_tests++; if ({load_done, load_ready} !== 2'b00) begin n_fail++; $display("FAIL after_load_idle: got done/ready=%b want 00", {load_done, load_ready}); end
    for (int i = 0; i < 20; i++) begin
      fetch_req = 1'b1; fetch_addr = 8'(i);
      tick();
      n_tests++;
      if ({instr_valid, addr_err, instr} !== {1'b1, 1'b0, mref[0][i]}) begin
        n_fail++; $display("FAIL b2b_fetch[%0d]: got v=%b e=%b %h want 1/0/%h", i, instr_valid, addr_err, instr, mref[0][i]);
      end
    end
    fetch_req = 1'b0;
    tick();
    n_tests++; if ({instr_valid, instr} !== {1'b0, mref[0][19]}) begin n_fail++; $display("FAIL idle_hold: got v=%b %h want 0/%h", instr_valid, instr, mref[0][19]); end
  endtask

  task automatic test_load_inactive();
    int sent, a;
    bit done_seen;
    logic [8:0] exp;
    logic [8:0] cnt;
    sent = 0; done_seen = 0; cnt = '0;
    for (int i = 0; i < 12; i++) wdat[i] = 9'($urandom_range(0, 511));
    load_start = 1'b1; load_bank = 2'd1;
    fetch_req = 1'b1; a = $urandom_range(0, 19); fetch_addr = 8'(a); exp = mref[0][a];
    tick();
    load_start = 1'b0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      n_tests++;
      if ({fetch_ready, instr_valid, instr} !== {2'b11, exp}) begin
        n_fail++; $display("FAIL fetch_during_load[%0d]: got r=%b v=%b %h want 1/1/%h", c, fetch_ready, instr_valid, instr, exp);
      end
      a = $urandom_range(0, 19); fetch_addr = 8'(a); exp = mref[0][a];
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = wdat[sent];
      load_last  = (sent == 11);
      if (load_valid && load_ready) sent++;
      tick();
      if (load_done) begin done_seen = 1; cnt = load_count; end
    end
    load_valid = 1'b0; load_last = 1'b0;
    for (int i = 0; i < 12; i++) mref[1][i] = wdat[i];
    n_tests++; if ({instr_valid, instr} !== {1'b1, exp}) begin n_fail++; $display("FAIL last_fetch_during_load: got v=%b %h want 1/%h", instr_valid, instr, exp); end
    n_tests++; if (cnt !== 9'd12) begin n_fail++; $display("FAIL inactive_load_count: got %0d want 12", cnt); end
    bank_sel = 2'd1; bank_sel_we = 1'b1;
    a = $urandom_range(0, 11); fetch_addr = 8'(a); exp = mref[0][a];
    tick();
    bank_sel_we = 1'b0;
    n_tests++; if ({active_bank, instr} !== {2'd1, exp}) begin n_fail++; $display("FAIL strobe_cycle_old_bank: got bank=%0d %h want 1/%h", active_bank, instr, exp); end
    a = $urandom_range(0, 11); fetch_addr = 8'(a); exp = mref[1][a];
    tick();
    n_tests++; if ({instr_valid, instr} !== {1'b1, exp}) begin n_fail++; $display("FAIL new_bank_fetch: got v=%b %h want 1/%h", instr_valid, instr, exp); end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_load_active();
    int pulses, lat, frh;
    logic [8:0] cnt;
    bank_sel = 2'd0; bank_sel_we = 1'b1; tick(); bank_sel_we = 1'b0;
    for (int i = 0; i < 8; i++) wdat[i] = 9'($urandom_range(0, 511));
    run_load(0, 8, 1'b1, 1'b1, pulses, lat, frh, cnt);
    for (int i = 0; i < 8; i++) mref[0][i] = wdat[i];
    n_tests++; if ({lat == 1, frh == 0} !== 2'b11) begin n_fail++; $display("FAIL active_stall: got lat=%0d ready_cycles=%0d want 1/0", lat, frh); end
    n_tests++; if ({pulses == 1, cnt} !== {1'b1, 9'd8}) begin n_fail++; $display("FAIL active_load_done: got pulses=%0d cnt=%0d want 1/8", pulses, cnt); end
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_done: got %b want 1", fetch_ready); end
    fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    n_tests++; if ({instr_valid, instr} !== {1'b1, mref[0][0]}) begin n_fail++; $display("FAIL new_word0: got v=%b %h want 1/%h", instr_valid, instr, mref[0][0]); end
    fetch_addr = 8'd12;
    tick();
    n_tests++; if (instr !== mref[0][12]) begin n_fail++; $display("FAIL untouched_word12: got %h want %h", instr, mref[0][12]); end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_bank_switch_midload();
    for (int i = 0; i < 6; i++) wdat[i] = 9'($urandom_range(0, 511));
    load_start = 1'b1; load_bank = 2'd2; tick(); load_start = 1'b0;
    for (int k = 0; k < 2; k++) begin load_valid = 1'b1; load_data = wdat[k]; tick(); end
    load_valid = 1'b0;
    n_tests++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL ready_before_switch: got %b want 1", fetch_ready); end
    bank_sel = 2'd2; bank_sel_we = 1'b1; fetch_req = 1'b1; fetch_addr = 8'd3;
    tick();
    bank_sel_we = 1'b0; fetch_addr = 8'd0;
    n_tests++; if ({instr_valid, instr} !== {1'b1, mref[0][3]}) begin n_fail++; $display("FAIL switch_cycle_fetch: got v=%b %h want 1/%h", instr_valid, instr, mref[0][3]); end
    n_tests++; if ({active_bank, fetch_ready} !== {2'd2, 1'b0}) begin n_fail++; $display("FAIL switch_stall: got bank=%0d ready=%b want 2/0", active_bank, fetch_ready); end
    for (int k = 2; k < 6; k++) begin
      load_valid = 1'b1; load_data = wdat[k]; load_last = (k == 5);
      tick();
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stalled_fetch[%0d]: got v=%b want 0", k, instr_valid); end
    end
    load_valid = 1'b0; load_last = 1'b0;
    for (int i = 0; i < 6; i++) mref[2][i] = wdat[i];
    n_tests++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL switch_load_done: got %b want 1", load_done); end
    tick();
    n_tests++; if ({instr_valid, instr} !== {1'b1, mref[2][0]}) begin n_fail++; $display("FAIL resume_fetch: got v=%b %h want 1/%h", instr_valid, instr, mref[2][0]); end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_midload();
    int pulses, lat, frh;
    logic [8:0] cnt;
    for (int i = 0; i < 10; i++) wdat[i] = 9'($urandom_range(0, 511));
    run_load(3, 10, 1'b1, 1'b0, pulses, lat, frh, cnt);
    for (int i = 0; i < 10; i++) mref[3][i] = wdat[i];
    n_tests++; if (cnt !== 9'd10) begin n_fail++; $display("FAIL old_load_count: got %0d want 10", cnt); end
    for (int i = 0; i < 10; i++) ndat[i] = ~wdat[i];
    load_start = 1'b1; load_bank = 2'd3; tick(); load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin load_valid = 1'b1; load_data = ndat[k]; tick(); end
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) mref[3][i] = ndat[i];
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++; if ({load_ready, load_done} !== 2'b00) begin n_fail++; $display("FAIL reset_midload: got ready/done=%b want 00", {load_ready, load_done}); end
    tick();
    n_tests++; if ({load_ready, load_done} !== 2'b00) begin n_fail++; $display("FAIL no_done_after_reset: got ready/done=%b want 00", {load_ready, load_done}); end
    bank_sel = 2'd3; bank_sel_we = 1'b1; tick(); bank_sel_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fetch_req = 1'b1; fetch_addr = 8'(i);
      tick();
      n_tests++; if ({instr_valid, instr} !== {1'b1, mref[3][i]}) begin n_fail++; $display("FAIL partial_load[%0d]: got v=%b %h want 1/%h", i, instr_valid, instr, mref[3][i]); end
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_depth16();
    int acc, done;
    logic [8:0] cnt;
    acc = 0; done = 0; cnt = '0;
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    s_fetch_req = 1'b1; s_fetch_addr = 8'd16;
    tick();
    n_tests++; if ({s_instr_valid, s_addr_err, s_instr} !== {2'b11, HALT}) begin n_fail++; $display("FAIL oor_16: got v=%b e=%b %h want 1/1/%h", s_instr_valid, s_addr_err, s_instr, HALT); end
    s_fetch_addr = 8'd255;
    tick();
    n_tests++; if ({s_instr_valid, s_addr_err, s_instr} !== {2'b11, HALT}) begin n_fail++; $display("FAIL oor_255: got v=%b e=%b %h want 1/1/%h", s_instr_valid, s_addr_err, s_instr, HALT); end
    s_fetch_req = 1'b0;
    tick();
    n_tests++; if ({s_instr_valid, s_addr_err} !== 2'b00) begin n_fail++; $display("FAIL idle_err_clear: got v/e=%b want 00", {s_instr_valid, s_addr_err}); end
    for (int i = 0; i < 17; i++) wdat[i] = 9'($urandom_range(0, 511));
    s_load_start = 1'b1; s_load_bank = 2'd0; tick(); s_load_start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      s_load_valid = 1'b1; s_load_data = wdat[k]; s_load_last = 1'b0;
      if (s_load_ready) acc++;
      tick();
      if (s_load_done) begin done++; cnt = s_load_count; end
    end
    s_load_valid = 1'b0;
    for (int i = 0; i < 16; i++) sref[i] = wdat[i];
    n_tests++; if (acc !== 16) begin n_fail++; $display("FAIL words_accepted: got %0d want 16", acc); end
    n_tests++; if ({done == 1, cnt} !== {1'b1, 9'd16}) begin n_fail++; $display("FAIL full_load_done: got pulses=%0d cnt=%0d want 1/16", done, cnt); end
    for (int i = 0; i < 16; i++) begin
      s_fetch_req = 1'b1; s_fetch_addr = 8'(i);
      tick();
      n_tests++; if ({s_instr_valid, s_addr_err, s_instr} !== {2'b10, sref[i]}) begin n_fail++; $display("FAIL d16_fetch[%0d]: got v=%b e=%b %h want 1/0/%h", i, s_instr_valid, s_addr_err, s_instr, sref[i]); end
    end
    s_fetch_req = 1'b0;
    s_bank_sel = 2'd3; s_bank_sel_we = 1'b1; tick();
    n_tests++; if (s_active_bank !== 2'd0) begin n_fail++; $display("FAIL bad_bank_sel: got %0d want 0", s_active_bank); end
    s_bank_sel = 2'd2; tick(); s_bank_sel_we = 1'b0;
    n_tests++; if (s_active_bank !== 2'd2) begin n_fail++; $display("FAIL good_bank_sel: got %0d want 2", s_active_bank); end
    s_load_start = 1'b1; s_load_bank = 2'd3; tick(); s_load_start = 1'b0;
    n_tests++; if (s_load_ready !== 1'b0) begin n_fail++; $display("FAIL bad_load_bank: got ready=%b want 0", s_load_ready); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; bank_sel = '0; bank_sel_we = 1'b0;
    load_start = 1'b0; load_bank = '0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    s_reset = 1'b1; s_fetch_req = 1'b0; s_fetch_addr = '0; s_bank_sel = '0; s_bank_sel_we = 1'b0;
    s_load_start = 1'b0; s_load_bank = '0; s_load_valid = 1'b0; s_load_last = 1'b0; s_load_data = '0;
    test_reset();
    test_load_fetch();
    test_load_inactive();
    test_load_active();
    test_bank_switch_midload();
    test_reset_midload();
    test_depth16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
